// File: rtl/exp_golomb_decoder.sv
// Exp-Golomb syntax element decoder (ue / se / te).
// Consumes bits from an external MSB-first bitstream window. The leading-zero
// count comes from an external heading-one detector. After each shift_en the
// buffer presents the advanced window in the next cycle.
// Optional feature: define EXP_GOLOMB_TE_EN to enable truncated (te) decoding.
// Without it, mode 2 decodes as ue and te_range is ignored.
//
//  state  | meaning
//  IDLE   | waiting for start
//  PREFIX | counting leading zeros (16 per all-zero window)
//  SUFFIX | collecting lz info bits, up to 16 per window
//  OUT    | one-cycle result: done pulse with value/error
module exp_golomb_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [4:0]  te_range,
   input  logic [15:0] BitStream_buffer_output,
   input  logic        BitStream_buffer_valid,
   input  logic [3:0]  heading_one_pos,
   output logic        shift_en,
   output logic [4:0]  shift_len,
   output logic        busy,
   output logic        done,
   output logic [31:0] value,
   output logic        error
);

   typedef enum logic [1:0] {IDLE, PREFIX, SUFFIX, OUT} state_t;

   state_t      state, state_nx;
   logic [5:0]  lz, lz_nx;
   logic [5:0]  rem, rem_nx;
   logic [31:0] info, info_nx;
   logic        is_se, is_se_nx;
   logic        err, err_nx;
   logic        shift_c;
   logic [4:0]  shift_len_c;

   logic        te_one;
   logic        te_bad;

`ifdef EXP_GOLOMB_TE_EN
   logic        is_te, is_te_nx;
   logic [4:0]  te_range_q, te_range_nx;

   assign te_one = is_te && (te_range_q == 5'd1);
   assign te_bad = is_te && (te_range_q == 5'd0);

   // te configuration latched at start, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         is_te      <= 1'b0;
         te_range_q <= 5'd0;
      end else begin
         is_te      <= is_te_nx;
         te_range_q <= te_range_nx;
      end
   end
`else
   logic unused_te_range;

   assign unused_te_range = ^te_range;
   assign te_one = 1'b0;
   assign te_bad = 1'b0;
`endif

   logic [5:0]  lz_sum;
   logic [6:0]  lz_plus16;
   logic [4:0]  n;
   logic [31:0] window_bits;

   assign lz_sum      = lz + {2'b00, heading_one_pos};
   assign lz_plus16   = {1'b0, lz} + 7'd16;
   assign n           = (rem > 6'd16) ? 5'd16 : rem[4:0];
   assign window_bits = {16'h0000, BitStream_buffer_output} >> (5'd16 - n);

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         lz    <= 6'd0;
         rem   <= 6'd0;
         info  <= 32'd0;
         is_se <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         lz    <= lz_nx;
         rem   <= rem_nx;
         info  <= info_nx;
         is_se <= is_se_nx;
         err   <= err_nx;
      end
   end

   // next-state, datapath update and shift request
   always_comb begin
      state_nx    = state;
      lz_nx       = lz;
      rem_nx      = rem;
      info_nx     = info;
      is_se_nx    = is_se;
      err_nx      = err;
      shift_c     = 1'b0;
      shift_len_c = 5'd0;
`ifdef EXP_GOLOMB_TE_EN
      is_te_nx    = is_te;
      te_range_nx = te_range_q;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = PREFIX;
               lz_nx    = 6'd0;
               rem_nx   = 6'd0;
               info_nx  = 32'd0;
               err_nx   = 1'b0;
               is_se_nx = (mode == 2'd1);
`ifdef EXP_GOLOMB_TE_EN
               is_te_nx    = (mode == 2'd2);
               te_range_nx = te_range;
`endif
            end
         end
         PREFIX: begin
            if (BitStream_buffer_valid) begin
               if (te_bad) begin
                  err_nx   = 1'b1;
                  state_nx = OUT;
               end else if (te_one) begin
                  // single inverted bit; lz stays 0 so codeNum equals info
                  shift_c     = 1'b1;
                  shift_len_c = 5'd1;
                  info_nx     = {31'd0, ~BitStream_buffer_output[15]};
                  state_nx    = OUT;
               end else if (BitStream_buffer_output != 16'h0000) begin
                  shift_c     = 1'b1;
                  shift_len_c = {1'b0, heading_one_pos} + 5'd1;
                  lz_nx       = lz_sum;
                  rem_nx      = lz_sum;
                  state_nx    = (lz_sum == 6'd0) ? OUT : SUFFIX;
               end else begin
                  shift_c     = 1'b1;
                  shift_len_c = 5'd16;
                  if (lz_plus16 > 7'd31) begin
                     err_nx   = 1'b1;
                     state_nx = OUT;
                  end else begin
                     lz_nx = lz_plus16[5:0];
                  end
               end
            end
         end
         SUFFIX: begin
            if (BitStream_buffer_valid) begin
               shift_c     = 1'b1;
               shift_len_c = n;
               info_nx     = (info << n) | window_bits;
               rem_nx      = rem - {1'b0, n};
               if (rem_nx == 6'd0) state_nx = OUT;
            end
         end
         OUT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   logic [31:0] code_num;
   logic [32:0] code_inc;
   logic [31:0] decoded;

   assign code_num = ((32'd1 << lz) - 32'd1) + info;
   assign code_inc = {1'b0, code_num} + 33'd1;

   // ue passes codeNum through; se maps odd to positive, even to negative
   always_comb begin
      decoded = code_num;
      if (is_se) begin
         if (code_num[0]) decoded = code_inc[32:1];
         else             decoded = 32'd0 - {1'b0, code_num[31:1]};
      end
   end

   assign busy      = (state != IDLE);
   assign shift_en  = shift_c && !reset;
   assign shift_len = (shift_c && !reset) ? shift_len_c : 5'd0;
   assign done      = (state == OUT) && !reset;
   assign error     = done && err;
   assign value     = (done && !err) ? decoded : 32'd0;

endmodule

// File: tb/tb_exp_golomb_decoder.sv
// Directed bench for exp_golomb_decoder. Models the bitstream buffer: after a
// shift_en the next prepared window is presented, with heading_one_pos derived
// from it.
module tb_exp_golomb_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [4:0]  te_range;
   logic [15:0] window;
   logic        valid;
   logic [3:0]  hop;
   logic        shift_en;
   logic [4:0]  shift_len;
   logic        busy;
   logic        done;
   logic [31:0] value;
   logic        error;

   int tests = 0;
   int fails = 0;

   logic [15:0] win [4];
   logic [4:0]  exp_sh [4];
   int          nwin;
   int          nsh;

   always #5 clk = ~clk;

   exp_golomb_decoder dut (
      .clk                     (clk),
      .reset                   (reset),
      .start                   (start),
      .mode                    (mode),
      .te_range                (te_range),
      .BitStream_buffer_output (window),
      .BitStream_buffer_valid  (valid),
      .heading_one_pos         (hop),
      .shift_en                (shift_en),
      .shift_len               (shift_len),
      .busy                    (busy),
      .done                    (done),
      .value                   (value),
      .error                   (error)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] lead_zeros(input logic [15:0] w);
      for (int i = 15; i >= 0; i--)
         if (w[i]) return 4'(15 - i);
      return 4'd15;
   endfunction

   task automatic set_win(input logic [15:0] w);
      window = w;
      hop    = lead_zeros(w);
   endtask

   // one element: win[0..nwin-1] presented in order, exp_sh[0..nsh-1] expected
   task automatic decode(input string tag, input logic [1:0] m, input logic [4:0] ter,
                         input int stall, input logic [31:0] exp_val,
                         input logic exp_err, input int exp_lat);
      int idx = 0;
      int k = 0;
      int cyc = 1;
      bit got = 0;
      bit shifted;
      @(posedge clk); #1;
      start = 1'b1; mode = m; te_range = ter;
      set_win(win[0]); valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      valid = (stall > 0) ? 1'b0 : 1'b1;
      while (cyc < 20 && !got) begin
         @(negedge clk);
         shifted = shift_en;
         if (shift_en) begin
            if (k < nsh) chk({tag, "_shift_len"}, 32'(shift_len), 32'(exp_sh[k]));
            else         chk({tag, "_extra_shift"}, 32'd1, 32'd0);
            k++;
         end
         if (done) begin
            got = 1;
            chk({tag, "_value"}, value, exp_val);
            chk({tag, "_error"}, 32'(error), 32'(exp_err));
            chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
         end
         @(posedge clk); #1;
         cyc++;
         if (shifted) begin
            idx++;
            set_win((idx < nwin) ? win[idx] : 16'h0000);
         end
         valid = (cyc <= stall) ? 1'b0 : 1'b1;
      end
      if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
      chk({tag, "_shift_count"}, 32'(k), 32'(nsh));
   endtask

   task automatic load(input int nw, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3,
                       input int ns, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] s3);
      nwin = nw; win[0] = w0; win[1] = w1; win[2] = w2; win[3] = w3;
      nsh = ns; exp_sh[0] = s0; exp_sh[1] = s1; exp_sh[2] = s2; exp_sh[3] = s3;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 2'd0; te_range = 5'd0;
      set_win(16'h0000); valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_shift_en", 32'(shift_en), 32'd0);
      chk("rst_value", value, 32'd0);
      chk("rst_error", 32'(error), 32'd0);

      load(1, 16'h8000, 0, 0, 0, 1, 5'd1, 0, 0, 0);
      decode("ue_zero", 2'd0, 5'd0, 0, 32'd0, 1'b0, 2);

      load(2, 16'h2800, 16'h4000, 0, 0, 2, 5'd3, 5'd2, 0, 0);
      decode("ue_four", 2'd0, 5'd0, 0, 32'd4, 1'b0, 3);
      decode("se_minus2", 2'd1, 5'd0, 0, 32'hFFFF_FFFE, 1'b0, 3);
      decode("ue_four_stall", 2'd0, 5'd0, 2, 32'd4, 1'b0, 5);

      load(2, 16'h2000, 16'h0000, 0, 0, 2, 5'd3, 5'd2, 0, 0);
      decode("se_plus2", 2'd1, 5'd0, 0, 32'd2, 1'b0, 3);

      load(2, 16'h3000, 16'h8000, 0, 0, 2, 5'd3, 5'd2, 0, 0);
      decode("se_plus3", 2'd1, 5'd0, 0, 32'd3, 1'b0, 3);

      load(2, 16'h4000, 16'h0000, 0, 0, 2, 5'd2, 5'd1, 0, 0);
      decode("se_plus1", 2'd1, 5'd0, 0, 32'd1, 1'b0, 3);

      load(2, 16'h4000, 16'h8000, 0, 0, 2, 5'd2, 5'd1, 0, 0);
      decode("rsvd_as_ue", 2'd3, 5'd0, 0, 32'd2, 1'b0, 3);

      load(4, 16'h0000, 16'h4000, 16'hFFFF, 16'h8000, 4, 5'd16, 5'd2, 5'd16, 5'd1);
      decode("ue_lz17", 2'd0, 5'd0, 0, 32'h0003_FFFE, 1'b0, 5);

      load(2, 16'h0000, 16'h0000, 0, 0, 2, 5'd16, 5'd16, 0, 0);
      decode("lz_overflow", 2'd0, 5'd0, 0, 32'd0, 1'b1, 3);

`ifdef EXP_GOLOMB_TE_EN
      load(1, 16'h8000, 0, 0, 0, 1, 5'd1, 0, 0, 0);
      decode("te1_bit1", 2'd2, 5'd1, 0, 32'd0, 1'b0, 2);
      load(1, 16'h0000, 0, 0, 0, 1, 5'd1, 0, 0, 0);
      decode("te1_bit0", 2'd2, 5'd1, 0, 32'd1, 1'b0, 2);
      load(1, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
      decode("te0_error", 2'd2, 5'd0, 0, 32'd0, 1'b1, 2);
      load(2, 16'h4000, 16'h8000, 0, 0, 2, 5'd2, 5'd1, 0, 0);
      decode("te5_as_ue", 2'd2, 5'd5, 0, 32'd2, 1'b0, 3);
`else
      load(2, 16'h4000, 16'h8000, 0, 0, 2, 5'd2, 5'd1, 0, 0);
      decode("te_off_as_ue", 2'd2, 5'd1, 0, 32'd2, 1'b0, 3);
`endif

      // reset while in SUFFIX, with start also high in the reset cycle
      @(posedge clk); #1;
      start = 1'b1; mode = 2'd0; set_win(16'h2800); valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("midrst_prefix_shift", 32'(shift_en), 32'd1);
      @(posedge clk); #1;
      set_win(16'h4000); reset = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("midrst_no_shift", 32'(shift_en), 32'd0);
      chk("midrst_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; valid = 1'b1;
      @(negedge clk);
      chk("postrst_busy", 32'(busy), 32'd0);
      chk("postrst_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("postrst_idle_busy", 32'(busy), 32'd0);

      load(1, 16'h8000, 0, 0, 0, 1, 5'd1, 0, 0, 0);
      decode("after_rst", 2'd0, 5'd0, 0, 32'd0, 1'b0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
